// File: rtl/restoring_divider.sv
// 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_DETECT_EN: a zero divisor finishes after one CALC cycle and raises div_by_zero.
module restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q;
  logic [7:0] dvd_q;
  logic [3:0] dvs_q;
  logic [4:0] prem_q;
  logic [7:0] qacc_q;
  logic [2:0] cnt_q;
  logic [7:0] quot_q;
  logic [3:0] rem_q;
  logic       busy_q;
  logic       done_q;

  logic [4:0] shift_d;
  logic       borrow_d;
  logic [4:0] prem_d;
  logic [7:0] qacc_d;

  // One restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shift_d  = 5'({prem_q, dvd_q[7]});
    borrow_d = shift_d < {1'b0, dvs_q};
    prem_d   = borrow_d ? shift_d : shift_d - {1'b0, dvs_q};
    qacc_d   = 8'({qacc_q, ~borrow_d});
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qacc_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            prem_q  <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
`ifdef DIV_ZERO_DETECT_EN
          if (dvs_q == 4'd0) begin
            quot_q  <= 8'hFF;
            rem_q   <= dvd_q[3:0];
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else
`endif
          begin
            prem_q <= prem_d;
            qacc_q <= qacc_d;
            dvd_q  <= {dvd_q[6:0], 1'b0};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              quot_q  <= qacc_d;
              rem_q   <= 4'(prem_d);
`ifdef DIV_ZERO_DETECT_EN
              dbz_q   <= 1'b0;
`endif
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
